multitrack_sequencer: RTL and testbench
=======================================

# multitrack_sequencer

Parametrised N-track note recorder/player that replaces the fixed two-track record/play/mix datapath. Step-records one note per record pulse into a per-track buffer, tracks each track's length, and plays back any subset of tracks (single or mixed) at a fixed step rate, once or looping. Sits between the debounced button/switch inputs and the audio tone generator and staff display, which consume `note_out` and `play_addr`.

## Interface
- `NUM_TRACKS`, 4, number of tracks (≥1)
- `NOTE_W`, 8, note word width; one-hot tone per bit
- `ADDR_W`, 6, log2 of per-track depth (DEPTH = 2^ADDR_W)
- `TICK_DIV`, 25_000_000, clock cycles per playback step (≥2)
- `SEL_W`, clog2(NUM_TRACKS) (min 1), track-select width

- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `record`  in  1  one-cycle pulse: append `note_in` to selected track
- `play`  in  1  one-cycle pulse: start playback (IDLE) / stop (PLAY)
- `erase`  in  1  one-cycle pulse: clear selected track's length
- `loop_en`  in  1  sampled at play start; 1 = repeat indefinitely
- `track_sel`  in  SEL_W  track for record/erase
- `mix_mask`  in  NUM_TRACKS  tracks to play; sampled at play start
- `note_in`  in  NOTE_W  note to record
- `note_out`  out  NOTE_W  registered bitwise OR of active tracks' notes
- `play_addr`  out  ADDR_W  current playback step
- `playing`  out  1  high in PLAY
- `done`  out  1  one-cycle pulse at end of non-looping playback
- `full`  out  1  selected track length == DEPTH
- `sel_len`  out  ADDR_W+1  length of selected track

## Operation
- Upstream debounce delivers `record`/`play`/`erase` as one-cycle pulses.
- Storage: NUM_TRACKS × DEPTH × NOTE_W array; per-track length `len[t]` (ADDR_W+1 bits, 0..DEPTH).
- States: IDLE, PLAY.
- IDLE, priority erase > play > record when pulses coincide; lower-priority pulses in same cycle dropped.
  - erase: `len[track_sel]` ← 0; data untouched.
  - record: if `len[track_sel]` < DEPTH, write `note_in` at address `len[track_sel]`, `len` +1; else ignored (no wrap, no overwrite).
  - play: latch `mask` ← `mix_mask`, `loop` ← `loop_en`, `plen` ← max `len[t]` over masked t. If `plen` == 0: stay IDLE, `done` pulses next cycle. Else → PLAY, `play_addr` ← 0, tick counter ← 0.
  - `track_sel` ≥ NUM_TRACKS: record/erase ignored, `full`=0, `sel_len`=0.
- PLAY:
  - `note_out` = OR over masked t with `play_addr` < `len[t]` of `mem[t][play_addr]`; tracks shorter than `plen` contribute 0.
  - Tick counter counts 0..TICK_DIV−1; at TICK_DIV−1 it wraps and step advances.
  - Advance at `play_addr` < `plen`−1: `play_addr` +1.
  - Advance at `play_addr` == `plen`−1: loop → `play_addr` ← 0; else → IDLE, `done` pulse, `play_addr` ← 0.
  - `play` pulse: → IDLE immediately, no `done`.
  - `record`, `erase`, `track_sel` changes ignored; lengths frozen during PLAY.
- IDLE: `note_out` = 0.

## Timing
- Reset (any state, incl. mid-playback): state IDLE, all `len` 0, tick 0, `play_addr` 0, `note_out` 0, `playing` 0, `done` 0; `full` 0, `sel_len` 0 follow from lengths. Array contents not cleared.
- Record: write and `len` increment on the edge sampling the pulse; `sel_len`/`full` updated next cycle.
- Erase: `sel_len`=0 the cycle after the pulse.
- Play start: `playing`=1 and `play_addr`=0 the cycle after the pulse; `note_out` valid for step 0 one further cycle later (2-cycle latency, synchronous array read).
- Each step lasts exactly TICK_DIV cycles; `note_out` lags `play_addr` by one cycle.
- Non-looping end: `done`=1, `playing`=0 in same cycle, TICK_DIV×`plen` cycles after `playing` rose; `note_out` 0 the cycle after.
- Stop: `playing`=0 the cycle after the `play` pulse; `note_out`=0 one cycle after that.
- `full`, `sel_len` combinational from `track_sel` and registered `len`.

## Test plan
- Reset, record 0x01,0x02,0x04 into track 0 → `sel_len`=3; play mask=0001, loop=0, TICK_DIV=4 → `note_out` 01,02,04 for 4 cycles each, `done` pulse 12 cycles after `playing` rises, `note_out` then 0.
- Track 0 = {0x01,0x02,0x04}, track 1 = {0x80}; play mask=0011 → `note_out` 0x81,0x02,0x04 (short track contributes 0), `plen`=3.
- Record DEPTH+1 notes into track 2 → `full`=1 after DEPTH writes, `sel_len`=DEPTH, extra write ignored; playback of last step returns note DEPTH, not the dropped one.
- loop_en=1, 2-note track → `play_addr` 0,1,0,1…, no `done`; `play` pulse → `playing`=0 next cycle, no `done`.
- Same-cycle erase+record on track 0 (len 3) → `sel_len`=0; play with empty mask or empty tracks → `done` next cycle, `playing` never 1.
- Assert `reset` mid-PLAY → next cycle `playing`=0, `note_out`=0, all lengths 0; subsequent play → immediate `done`.

Source files
------------

// File: rtl/multitrack_sequencer.sv
// rtl/multitrack_sequencer.sv - N-track step recorder with mixed, one-shot or looping playback
module multitrack_sequencer #(
    parameter int NUM_TRACKS = 4,
    parameter int NOTE_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int TICK_DIV   = 25_000_000,
    parameter int SEL_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  record,
    input  logic                  play,
    input  logic                  erase,
    input  logic                  loop_en,
    input  logic [SEL_W-1:0]      track_sel,
    input  logic [NUM_TRACKS-1:0] mix_mask,
    input  logic [NOTE_W-1:0]     note_in,
    output logic [NOTE_W-1:0]     note_out,
    output logic [ADDR_W-1:0]     play_addr,
    output logic                  playing,
    output logic                  done,
    output logic                  full,
    output logic [ADDR_W:0]       sel_len
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int TICK_W = $clog2(TICK_DIV);

    localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_t;

    state_t state;
    state_t next_state;

    // Note storage and per-track fill level; contents survive reset and erase
    logic [NOTE_W-1:0] mem [NUM_TRACKS][DEPTH];
    logic [LEN_W-1:0]  len [NUM_TRACKS];

    // Playback context captured when a run starts
    logic [NUM_TRACKS-1:0] mask_q;
    logic                  loop_q;
    logic [LEN_W-1:0]      plen_q;
    logic [TICK_W-1:0]     tick;

    logic                  sel_ok;
    logic                  sel_full;
    logic                  is_idle;
    logic                  is_play;
    logic                  erase_go;
    logic                  play_go;
    logic                  record_go;
    logic                  step_wrap;
    logic                  last_step;
    logic                  run_end;
    logic [LEN_W-1:0]      play_len;
    logic [NOTE_W-1:0]     mix_note;

    assign sel_ok   = (32'(track_sel) < NUM_TRACKS);
    assign sel_full = sel_ok && (len[track_sel] == DEPTH_LEN);
    assign sel_len  = sel_ok ? len[track_sel] : '0;
    assign full     = sel_full;

    assign is_idle   = (state == S_IDLE);
    assign is_play   = (state == S_PLAY);

    // Erase outranks play, which outranks record; losers in the same cycle are dropped
    assign erase_go  = is_idle && erase && sel_ok;
    assign play_go   = is_idle && play && !erase;
    assign record_go = is_idle && record && !erase && !play && sel_ok && !sel_full;

    assign step_wrap = is_play && (tick == TICK_LAST);
    assign last_step = ({1'b0, play_addr} == (plen_q - LEN_W'(1)));
    assign run_end   = is_play && !play && step_wrap && last_step && !loop_q;

    // Playback length is the longest of the tracks selected for the run
    always_comb begin
        play_len = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            if (mix_mask[t] && (len[t] > play_len)) begin
                play_len = len[t];
            end
        end
    end

    // Mix of the current step; tracks already exhausted contribute nothing
    always_comb begin
        mix_note = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            if (mask_q[t] && ({1'b0, play_addr} < len[t])) begin
                mix_note = mix_note | mem[t][play_addr];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: an empty run never leaves IDLE
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (play_go && (play_len != '0)) begin
                    next_state = S_PLAY;
                end
            end
            S_PLAY: begin
                if (play || run_end) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        playing = (state == S_PLAY);
    end

    // Note array write port; only the append position of the selected track is written
    always_ff @(posedge clock) begin
        if (!reset && record_go) begin
            mem[track_sel][len[track_sel][ADDR_W-1:0]] <= note_in;
        end
    end

    // Track lengths: erase clears, record appends, frozen outside IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                len[t] <= '0;
            end
        end else if (erase_go) begin
            len[track_sel] <= '0;
        end else if (record_go) begin
            len[track_sel] <= len[track_sel] + LEN_W'(1);
        end
    end

    // Run context, step timer and step address
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q    <= '0;
            loop_q    <= 1'b0;
            plen_q    <= '0;
            tick      <= '0;
            play_addr <= '0;
        end else begin
            if (play_go) begin
                mask_q <= mix_mask;
                loop_q <= loop_en;
                plen_q <= play_len;
            end
            if (is_play && (next_state == S_PLAY)) begin
                tick <= step_wrap ? '0 : tick + TICK_W'(1);
            end else begin
                tick <= '0;
            end
            if (play_go || (is_play && play)) begin
                play_addr <= '0;
            end else if (step_wrap) begin
                play_addr <= last_step ? '0 : play_addr + ADDR_W'(1);
            end
        end
    end

    // Registered mix output and end-of-run pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            note_out <= '0;
            done     <= 1'b0;
        end else begin
            note_out <= is_play ? mix_note : '0;
            done     <= (play_go && (play_len == '0)) || run_end;
        end
    end

endmodule

// File: tb/tb_multitrack_sequencer.sv
// tb/tb_multitrack_sequencer.sv - scoreboard bench for multitrack_sequencer
module tb_multitrack_sequencer;

    localparam int NT    = 4;
    localparam int NW    = 8;
    localparam int AW    = 3;
    localparam int TD    = 4;
    localparam int DEPTH = 8;
    localparam int SW    = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          record;
    logic          play;
    logic          erase;
    logic          loop_en;
    logic [SW-1:0] track_sel;
    logic [NT-1:0] mix_mask;
    logic [NW-1:0] note_in;
    logic [NW-1:0] note_out;
    logic [AW-1:0] play_addr;
    logic          playing;
    logic          done;
    logic          full;
    logic [AW:0]   sel_len;

    multitrack_sequencer #(
        .NUM_TRACKS(NT),
        .NOTE_W    (NW),
        .ADDR_W    (AW),
        .TICK_DIV  (TD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .record   (record),
        .play     (play),
        .erase    (erase),
        .loop_en  (loop_en),
        .track_sel(track_sel),
        .mix_mask (mix_mask),
        .note_in  (note_in),
        .note_out (note_out),
        .play_addr(play_addr),
        .playing  (playing),
        .done     (done),
        .full     (full),
        .sel_len  (sel_len)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit            is_done;
        int            at;
        logic [AW-1:0] addr;
        logic [NW-1:0] note;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: notes and lengths per track
    logic [NW-1:0] mmem [NT][DEPTH];
    int            mlen [NT];

    function automatic logic [NW-1:0] mix_at(input logic [NT-1:0] m, input int a);
        logic [NW-1:0] r;
        r = '0;
        for (int t = 0; t < NT; t++)
            if (m[t] && a < mlen[t]) r = r | mmem[t][a];
        return r;
    endfunction

    function automatic int plen_of(input logic [NT-1:0] m);
        int r;
        r = 0;
        for (int t = 0; t < NT; t++)
            if (m[t] && mlen[t] > r) r = mlen[t];
        return r;
    endfunction

    task automatic push_step(input int at, input int a, input logic [NT-1:0] m);
        exp_t e;
        e.is_done = 1'b0;
        e.at      = at;
        e.addr    = AW'(a);
        e.note    = mix_at(m, a);
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int at);
        exp_t e;
        e.is_done = 1'b1;
        e.at      = at;
        e.addr    = '0;
        e.note    = '0;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // One pulse cycle; the model applies erase > play > record and predicts playback.
    // Looping runs get expectations for steps 0..nloop.
    task automatic pulse(input bit e, input bit pl, input bit r, input int t,
                         input logic [NW-1:0] n, input logic [NT-1:0] m, input bit lp,
                         input int nloop, output int p, output int plen);
        @(negedge clock);
        erase     = e;
        play      = pl;
        record    = r;
        track_sel = SW'(t);
        note_in   = n;
        mix_mask  = m;
        loop_en   = lp;
        p         = cyc;
        plen      = 0;
        if (e) begin
            mlen[t] = 0;
        end else if (pl) begin
            plen = plen_of(m);
            if (plen == 0) begin
                push_done(p + 1);
            end else if (!lp) begin
                for (int k = 0; k < plen; k++) push_step(p + 1 + k * TD, k, m);
                push_done(p + 1 + plen * TD);
            end else begin
                for (int k = 0; k <= nloop; k++) push_step(p + 1 + k * TD, k % plen, m);
            end
        end else if (r && mlen[t] < DEPTH) begin
            mmem[t][mlen[t]] = n;
            mlen[t]++;
        end
        @(negedge clock);
        erase  = 1'b0;
        play   = 1'b0;
        record = 1'b0;
        check("sel_len", 32'(sel_len), mlen[t]);
        check("full", 32'(full), 32'(mlen[t] == DEPTH));
    endtask

    task automatic rec(input int t, input logic [NW-1:0] n);
        int p, pl;
        pulse(0, 0, 1, t, n, '0, 0, 0, p, pl);
    endtask

    task automatic run_once(input logic [NT-1:0] m);
        int p, pl;
        pulse(0, 1, 0, 0, 8'h00, m, 0, 0, p, pl);
        wait_until(p + 3 + pl * TD);
    endtask

    // Monitor: pops expectations whenever the DUT starts a step or pulses done
    initial begin
        logic          prev_play;
        logic [AW-1:0] prev_addr;
        bit            pend;
        bit            idle_chk;
        logic [NW-1:0] pend_note;
        exp_t          e;
        prev_play = 1'b0;
        prev_addr = '0;
        pend      = 0;
        idle_chk  = 0;
        pend_note = '0;
        forever begin
            @(negedge clock);
            if (pend) begin
                check("step_note", 32'(note_out), 32'(pend_note));
                pend = 0;
            end
            if (idle_chk) begin
                check("idle_note", 32'(note_out), 0);
                idle_chk = 0;
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: at cycle %0d pending=%0d", cyc, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.at);
                    check("done_playing", 32'(playing), 0);
                end
            end
            if (playing === 1'b1 && (!prev_play || play_addr !== prev_addr)) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_step: addr %0d at cycle %0d", play_addr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("step_cycle", cyc, e.at);
                    check("step_addr", 32'(play_addr), 32'(e.addr));
                    pend      = 1;
                    pend_note = e.note;
                end
            end
            if (playing !== 1'b1 && prev_play) idle_chk = 1;
            prev_play = (playing === 1'b1);
            prev_addr = play_addr;
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, pl, s;
        reset     = 1'b1;
        record    = 1'b0;
        play      = 1'b0;
        erase     = 1'b0;
        loop_en   = 1'b0;
        track_sel = '0;
        mix_mask  = '0;
        note_in   = '0;
        for (int t = 0; t < NT; t++) mlen[t] = 0;
        repeat (3) @(negedge clock);
        check("rst_playing", 32'(playing), 0);
        check("rst_done", 32'(done), 0);
        check("rst_note", 32'(note_out), 0);
        check("rst_addr", 32'(play_addr), 0);
        check("rst_sel_len", 32'(sel_len), 0);
        check("rst_full", 32'(full), 0);
        reset = 1'b0;
        @(negedge clock);

        // Single-track one-shot
        rec(0, 8'h01);
        rec(0, 8'h02);
        rec(0, 8'h04);
        run_once(4'b0001);

        // Mixed, shorter track contributes only its first step
        rec(1, 8'h80);
        run_once(4'b0011);

        // Overfill track 2; the extra note is dropped
        for (int i = 0; i <= DEPTH; i++) rec(2, NW'($urandom_range(1, 255)));
        run_once(4'b0100);

        // Looping two-note track, stopped by play
        rec(3, 8'h10);
        rec(3, 8'h20);
        pulse(0, 1, 0, 0, 8'h00, 4'b1000, 1, 5, p, pl);
        s = p + 1 + 5 * TD;
        wait_until(s);
        play = 1'b1;
        @(negedge clock);
        play = 1'b0;
        check("stop_playing", 32'(playing), 0);
        @(negedge clock);
        check("stop_note", 32'(note_out), 0);
        repeat (4) @(negedge clock);

        // Erase beats record; empty runs finish immediately
        pulse(1, 0, 1, 0, 8'h55, '0, 0, 0, p, pl);
        run_once(4'b0000);
        run_once(4'b0001);

        // Play beats record
        pulse(0, 1, 1, 1, 8'h33, 4'b0010, 0, 0, p, pl);
        wait_until(p + 3 + pl * TD);

        // Random operation mix
        for (int i = 0; i < 40; i++) begin
            bit e, pl_b, r;
            e    = ($urandom_range(0, 7) == 0);
            pl_b = ($urandom_range(0, 4) == 0);
            r    = ($urandom_range(0, 3) != 0);
            pulse(e, pl_b, r, $urandom_range(0, NT - 1), NW'($urandom_range(1, 255)),
                  NT'($urandom_range(0, 15)), 0, 0, p, pl);
            if (pl_b && !e) wait_until(p + 3 + pl * TD);
        end

        // Reset in the middle of a looping run
        pulse(1, 0, 0, 2, 8'h00, '0, 0, 0, p, pl);
        rec(2, 8'h11);
        rec(2, 8'h22);
        rec(2, 8'h44);
        pulse(0, 1, 0, 0, 8'h00, 4'b0100, 1, 4, p, pl);
        s = p + 1 + 4 * TD;
        wait_until(s + 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_playing", 32'(playing), 0);
        check("mid_rst_note", 32'(note_out), 0);
        check("mid_rst_addr", 32'(play_addr), 0);
        for (int t = 0; t < NT; t++) mlen[t] = 0;
        for (int t = 0; t < NT; t++) begin
            track_sel = SW'(t);
            #1;
            check("mid_rst_len", 32'(sel_len), 0);
        end
        run_once(4'b1111);
        rec(1, 8'h08);
        run_once(4'b0010);

        repeat (4) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
